lcd_bus_receiver: RTL and testbench
===================================

# lcd_bus_receiver

Receiving end of the HD44780-style 8-bit parallel bus driven by `lcd_disp_interface`. It samples E/RS/RW/DB and decodes instructions. It keeps an 80-byte DDRAM image with address counter, entry mode and display flags, and models busy time. It is used in benches as the display model and as a self-check point for the clock's LCD path.

## Interface
Parameters:
- `BUSY_CYCLES`, 100: busy duration after any accepted write except clear.
- `CLEAR_CYCLES`, 200: busy duration after clear display and after reset release. Must be ≥ 80.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `lcd_e`, in, 1: enable strobe, synchronous to `clk`.
- `lcd_rs`, in, 1: 0 = instruction, 1 = data.
- `lcd_rw`, in, 1: 0 = write, 1 = read.
- `lcd_db`, in, 8: data bus.
- `busy`, out, 1: busy flag.
- `cmd_valid`, out, 1: one-cycle pulse when an instruction is accepted.
- `cmd_code`, out, 8: last accepted instruction byte.
- `char_valid`, out, 1: one-cycle pulse when a data byte is written.
- `char_code`, out, 8: last written character.
- `char_addr`, out, 7: DDRAM address the character was written to.
- `addr_cnt`, out, 7: current address counter.
- `disp_on`, out, 1: display-on flag.
- `err`, out, 1: one-cycle pulse on a protocol violation.
- `rd_addr`, in, 7: DDRAM inspection address.
- `rd_data`, out, 8: DDRAM content at `rd_addr`, combinational.

## Operation
- **Sampling:**
  - `lcd_e` is registered once as `e_q`.
  - A transaction occurs on the falling edge, i.e. `e_q`=1 and `lcd_e`=0.
  - `lcd_rs`, `lcd_rw` and `lcd_db` are sampled in that same cycle.
- **Read transactions:** `lcd_rw`=1 transactions are ignored and have no side effects.
- **Write while busy:** the write is dropped and `err` pulses. State is unchanged.
- **Instruction decode:** priority is highest set bit.
  - `1xxxxxxx` (set DDRAM address):
    - Valid ranges are 0x00–0x27 and 0x40–0x67.
    - Any other address: `err` pulses, the counter is unchanged, no busy.
  - `01xxxxxx` (CGRAM address): accepted, no state effect.
  - `001xxxxx` (function set): accepted, no state effect.
  - `0001xxxx` (cursor/display shift): accepted, no state effect.
  - `00001DCB` (display control): `disp_on` ← D.
  - `000001IS` (entry mode): the increment flag ← I. S is ignored.
  - `0000001x` (return home): `addr_cnt` ← 0.
  - `00000001` (clear display):
    - Fills DDRAM with 0x20, one location per cycle, over 80 cycles.
    - `addr_cnt` ← 0, increment flag ← 1.
  - `00000000`: `err` pulses, not accepted.
- **Data write:**
  - DDRAM[`addr_cnt`] ← `lcd_db`, and `char_valid`, `char_code`, `char_addr` update.
  - The counter then steps with wrap:
    - Increment: 0x27→0x40, 0x67→0x00.
    - Decrement: 0x00→0x67, 0x40→0x27.
- **States:**
  - IDLE: accepts writes.
  - BUSY: counts down, ignores writes.
  - CLEAR: fills DDRAM, counts down.
  - Transitions:
    - IDLE → BUSY on an accepted non-clear write.
    - IDLE → CLEAR on clear display.
    - BUSY/CLEAR → IDLE when the counter reaches 0.
- **Reset (`rst`=0), all immediate:**
  - Outputs: `busy`=0, `cmd_valid`=`char_valid`=`err`=0, `cmd_code`=`char_code`=0, `char_addr`=`addr_cnt`=0, `disp_on`=0.
  - Internal: increment flag=1, `e_q`=0.
  - DDRAM contents are not reset.
  - After release the block enters CLEAR, so the power-on fill is modelled.
- **Reset mid-operation:** aborts the busy count or fill. The fill restarts from location 0 after release.

## Timing
- Falling edge seen in cycle n: `cmd_valid`/`char_valid`/`err` pulse in cycle n+1, together with the updated outputs and `addr_cnt`.
- Write to DDRAM is visible on `rd_data` from cycle n+1.
- `busy` is 1 from cycle n+1 for exactly `BUSY_CYCLES` cycles, or `CLEAR_CYCLES` for clear.
- A falling edge in the first cycle `busy`=0 is accepted.
- Clear fill occupies cycles n+1 … n+80. Location k is written in cycle n+1+k.
- After reset release, `busy` is 1 for `CLEAR_CYCLES` cycles starting at the first clock.
- A falling edge coinciding with `busy` deasserting to 0 counts as busy: the write is dropped and `err` pulses.

## Structure
- Shared package `lcd_pkg`:
  - Instruction opcode masks.
  - Line base addresses 0x00/0x40, line end addresses 0x27/0x67.
  - Blank character 0x20.
  - DDRAM depth 80.
  - The same package is used by `lcd_disp_interface`.
- Address mapping 7-bit → 0..79 index: line 1 maps 0x00–0x27 → 0–39, line 2 maps 0x40–0x67 → 40–79.
- One sub-module, `lcd_ddram`: 80×8 storage, synchronous write, asynchronous read, two read/write address ports (write port plus inspection read).

## Test plan
- **Reset:** release `rst` → `busy`=1 for exactly 200 cycles, then all DDRAM `rd_data`=0x20, `addr_cnt`=0.
- **Address + data write:**
  - Write 0x80|0x05, then wait busy.
  - Write data 0x31 (RS=1) → `char_valid` pulse, `char_addr`=0x05, `addr_cnt`=0x06, `rd_addr`=0x05 gives 0x31.
- **Wrap-around:**
  - Set address 0x27, write 'A' → `addr_cnt`=0x40.
  - Entry mode 0x04 (decrement), set address 0x00, write 'B' → `addr_cnt`=0x67.
- **Errors:**
  - Set address 0xA8 (0x28) → `err` pulse, `addr_cnt` unchanged, `busy` stays 0.
  - Write during `busy` → `err` pulse, DDRAM unchanged.
- **Clear plus display control:**
  - Display control 0x0C → `disp_on`=1.
  - Clear 0x01 → `busy` for 200 cycles, all locations 0x20, `disp_on` still 1.
- **Reset mid-clear:** assert `rst` at fill location 30 → outputs are 0 immediately. After release, a full fill runs and all locations read 0x20.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lcd_pkg : shared HD44780 bus constants, state encoding, address helpers |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package lcd_pkg;

  localparam logic [7:0] c_OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] c_OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] c_OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] c_OP_SHIFT     = 8'h10;
  localparam logic [7:0] c_OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] c_OP_ENTRY     = 8'h04;
  localparam logic [7:0] c_OP_HOME      = 8'h02;
  localparam logic [7:0] c_OP_CLEAR     = 8'h01;
  localparam logic [7:0] c_OP_NOP_MASK  = c_OP_SET_CGRAM | c_OP_FUNC_SET | c_OP_SHIFT;

  localparam logic [6:0] c_LINE1_BASE = 7'h00;
  localparam logic [6:0] c_LINE2_BASE = 7'h40;
  localparam logic [6:0] c_LINE1_END  = 7'h27;
  localparam logic [6:0] c_LINE2_END  = 7'h67;
  localparam logic [6:0] c_LINE_LEN   = 7'd40;
  localparam logic [7:0] c_BLANK      = 8'h20;
  localparam int         c_DDRAM_DEPTH = 80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CLEAR = 2'd2
  } lcd_state_t;

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= c_LINE1_END) || ((a >= c_LINE2_BASE) && (a <= c_LINE2_END));
  endfunction

  function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
    return a[6] ? (a - c_LINE2_BASE + c_LINE_LEN) : a;
  endfunction

  // Line ends chain into each other so the counter never leaves the valid map.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == c_LINE1_END) return c_LINE2_BASE;
      if (a == c_LINE2_END) return c_LINE1_BASE;
      return a + 7'd1;
    end
    if (a == c_LINE1_BASE) return c_LINE2_END;
    if (a == c_LINE2_BASE) return c_LINE1_END;
    return a - 7'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ddram.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lcd_ddram : 80x8 display RAM, synchronous write, asynchronous read      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module lcd_ddram #(
  parameter int DEPTH = 80
) (
  input  logic       clk,
  input  logic       i_we,
  input  logic [6:0] i_wr_idx,
  input  logic [7:0] i_wr_data,
  input  logic [6:0] i_rd_idx,
  output logic [7:0] o_rd_data
);

  logic [7:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we && (i_wr_idx < 7'(DEPTH))) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = (i_rd_idx < 7'(DEPTH)) ? r_mem[i_rd_idx] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/lcd_bus_receiver.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lcd_bus_receiver : HD44780-style 8-bit bus slave with DDRAM and busy    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 100,
  parameter int CLEAR_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic [6:0] char_addr,
  output logic [6:0] addr_cnt,
  output logic       disp_on,
  output logic       err,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] c_BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_RESET_LOAD = CNT_W'(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

  lcd_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_fill_idx;
  logic             r_e_q;
  logic             r_inc;
  logic             r_busy, r_cmd_valid, r_char_valid, r_err, r_disp_on;
  logic [7:0]       r_cmd_code, r_char_code;
  logic [6:0]       r_char_addr, r_addr_cnt;

  logic       w_wr, w_cmd_ok, w_cmd_clr, w_fill_we, w_data_we, w_mem_we;
  logic [6:0] w_mem_idx, w_rd_idx;
  logic [7:0] w_mem_data;

  assign w_wr      = r_e_q & ~lcd_e & ~lcd_rw;
  assign w_data_we = w_wr & lcd_rs & (r_state == ST_IDLE);
  // Gated by rst so the held-in-reset fill pointer never touches the RAM.
  assign w_fill_we = rst && (r_state == ST_CLEAR) && (r_fill_idx < 7'(c_DDRAM_DEPTH));

  assign w_mem_we   = w_data_we | w_fill_we;
  assign w_mem_idx  = w_fill_we ? r_fill_idx : addr_to_idx(r_addr_cnt);
  assign w_mem_data = w_fill_we ? c_BLANK : lcd_db;
  assign w_rd_idx   = addr_valid(rd_addr) ? addr_to_idx(rd_addr) : 7'h7F;

  always_comb begin
    w_cmd_ok  = 1'b0;
    w_cmd_clr = 1'b0;
    if (|(lcd_db & c_OP_SET_DDRAM)) begin
      w_cmd_ok = addr_valid(lcd_db[6:0]);
    end else if (lcd_db == c_OP_CLEAR) begin
      w_cmd_ok  = 1'b1;
      w_cmd_clr = 1'b1;
    end else begin
      w_cmd_ok = (lcd_db != 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_CLEAR;
      r_cnt        <= c_RESET_LOAD;
      r_fill_idx   <= '0;
      r_e_q        <= 1'b0;
      r_inc        <= 1'b1;
      r_busy       <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_char_valid <= 1'b0;
      r_err        <= 1'b0;
      r_disp_on    <= 1'b0;
      r_cmd_code   <= '0;
      r_char_code  <= '0;
      r_char_addr  <= '0;
      r_addr_cnt   <= '0;
    end else begin
      r_e_q        <= lcd_e;
      r_cmd_valid  <= 1'b0;
      r_char_valid <= 1'b0;
      r_err        <= 1'b0;
      if (w_fill_we) r_fill_idx <= r_fill_idx + 7'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_wr) begin
            if (lcd_rs) begin
              r_char_valid <= 1'b1;
              r_char_code  <= lcd_db;
              r_char_addr  <= r_addr_cnt;
              r_addr_cnt   <= addr_step(r_addr_cnt, r_inc);
              r_state      <= ST_BUSY;
              r_cnt        <= c_BUSY_LOAD;
              r_busy       <= 1'b1;
            end else if (!w_cmd_ok) begin
              r_err <= 1'b1;
            end else begin
              r_cmd_valid <= 1'b1;
              r_cmd_code  <= lcd_db;
              r_busy      <= 1'b1;
              if (|(lcd_db & c_OP_SET_DDRAM)) begin
                r_addr_cnt <= lcd_db[6:0];
              end else if (!(|(lcd_db & c_OP_NOP_MASK))) begin
                if (|(lcd_db & c_OP_DISP_CTRL)) begin
                  r_disp_on <= lcd_db[2];
                end else if (|(lcd_db & c_OP_ENTRY)) begin
                  r_inc <= lcd_db[1];
                end else begin
                  r_addr_cnt <= '0;
                  if (w_cmd_clr) r_inc <= 1'b1;
                end
              end
              if (w_cmd_clr) begin
                r_state    <= ST_CLEAR;
                r_cnt      <= c_CLEAR_LOAD;
                r_fill_idx <= '0;
              end else begin
                r_state <= ST_BUSY;
                r_cnt   <= c_BUSY_LOAD;
              end
            end
          end
        end
        default: begin
          if (w_wr) r_err <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - c_ONE;
            r_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  lcd_ddram #(.DEPTH(c_DDRAM_DEPTH)) u_ddram (
    .clk       (clk),
    .i_we      (w_mem_we),
    .i_wr_idx  (w_mem_idx),
    .i_wr_data (w_mem_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (rd_data)
  );

  assign busy       = r_busy;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_code   = r_cmd_code;
  assign char_valid = r_char_valid;
  assign char_code  = r_char_code;
  assign char_addr  = r_char_addr;
  assign addr_cnt   = r_addr_cnt;
  assign disp_on    = r_disp_on;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_receiver.sv
`default_nettype none
// tb_lcd_bus_receiver: directed vector table, corner sequences and random
// transactions checked against a transaction-level display model.
module tb_lcd_bus_receiver;

  localparam int B = 100;
  localparam int C = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_db = 8'h00;
  logic [6:0] rd_addr = 7'h00;
  logic       busy, cmd_valid, char_valid, disp_on, err;
  logic [7:0] cmd_code, char_code, rd_data;
  logic [6:0] char_addr, addr_cnt;

  lcd_bus_receiver #(.BUSY_CYCLES(B), .CLEAR_CYCLES(C)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db(lcd_db), .busy(busy), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .char_valid(char_valid), .char_code(char_code), .char_addr(char_addr),
    .addr_cnt(addr_cnt), .disp_on(disp_on), .err(err), .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Model state: DDRAM keyed by bus address, last-busy cycle number.
  logic [7:0] m_mem [0:127];
  logic [6:0] valid_addrs [0:79];
  logic [6:0] m_addr, m_char_addr;
  logic [7:0] m_cmd_code, m_char_code;
  logic       m_inc, m_disp;
  int         m_busy_end = 0;
  logic       e_cmd = 1'b0, e_char = 1'b0, e_err = 1'b0;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    logic       x_err;
    logic       x_cmd;
    logic       x_char;
    logic [6:0] x_addr;
    logic       x_disp;
    logic       x_busy;
  } vec_t;
  vec_t tbl [0:11];

  function automatic vec_t mk(input logic rs, input logic [7:0] db, input logic er,
                              input logic cv, input logic chv, input logic [6:0] ad,
                              input logic dn, input logic bs);
    vec_t v;
    v.rs = rs; v.db = db; v.x_err = er; v.x_cmd = cv; v.x_char = chv;
    v.x_addr = ad; v.x_disp = dn; v.x_busy = bs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  function automatic int addr_pos(input logic [6:0] a);
    for (int i = 0; i < 80; i++) if (valid_addrs[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
    int p;
    p = addr_pos(a);
    p = inc ? (p + 1) % 80 : (p + 79) % 80;
    return valid_addrs[p];
  endfunction

  task automatic model_reset(input int release_cyc);
    m_addr = '0; m_char_addr = '0; m_cmd_code = '0; m_char_code = '0;
    m_disp = 1'b0; m_inc = 1'b1;
    m_busy_end = release_cyc + C;
    for (int i = 0; i < 80; i++) m_mem[valid_addrs[i]] = 8'h20;
    e_cmd = 1'b0; e_char = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_xfer(input logic rs, input logic rw, input logic [7:0] db, input int n);
    e_cmd = 1'b0; e_char = 1'b0; e_err = 1'b0;
    if (rw) return;
    if (n <= m_busy_end) begin
      e_err = 1'b1;
      return;
    end
    if (rs) begin
      m_mem[m_addr] = db;
      m_char_code = db;
      m_char_addr = m_addr;
      e_char = 1'b1;
      m_addr = next_addr(m_addr, m_inc);
      m_busy_end = n + B;
      return;
    end
    if (db == 8'h00 || (db[7] && addr_pos(db[6:0]) < 0)) begin
      e_err = 1'b1;
      return;
    end
    e_cmd = 1'b1;
    m_cmd_code = db;
    m_busy_end = n + B;
    casez (db)
      8'b1???????: m_addr = db[6:0];
      8'b00001???: m_disp = db[2];
      8'b000001??: m_inc = db[1];
      8'b0000001?: m_addr = '0;
      8'b00000001: begin
        m_addr = '0;
        m_inc = 1'b1;
        m_busy_end = n + C;
        for (int i = 0; i < 80; i++) m_mem[valid_addrs[i]] = 8'h20;
      end
      default: begin end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".cmd_valid"},  cmd_valid,  e_cmd);
    chk({tag, ".char_valid"}, char_valid, e_char);
    chk({tag, ".err"},        err,        e_err);
    chk({tag, ".cmd_code"},   cmd_code,   m_cmd_code);
    chk({tag, ".char_code"},  char_code,  m_char_code);
    chk({tag, ".char_addr"},  char_addr,  m_char_addr);
    chk({tag, ".addr_cnt"},   addr_cnt,   m_addr);
    chk({tag, ".disp_on"},    disp_on,    m_disp);
    chk({tag, ".busy"},       busy,       (cyc <= m_busy_end));
  endtask

  // Raise E for one cycle, drop it in cycle n; outputs are sampled in n+1.
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] db, input string tag);
    int n;
    lcd_rs = rs; lcd_rw = rw; lcd_db = db; lcd_e = 1'b1;
    tick();
    lcd_e = 1'b0;
    n = cyc;
    tick();
    model_xfer(rs, rw, db, n);
    check_outputs(tag);
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 80; i++) begin
      rd_addr = valid_addrs[i];
      #1;
      if (rd_data !== m_mem[valid_addrs[i]]) bad++;
    end
    chk({tag, ".mem_mismatches"}, bad, 0);
  endtask

  task automatic busy_len(input string tag);
    int n;
    n = busy ? 1 : 0;
    for (int k = 0; k < C + 20; k++) begin
      tick();
      if (busy) n++;
    end
    chk({tag, ".busy_cycles"}, n, C);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 40; i++) begin
      valid_addrs[i]      = 7'(i);
      valid_addrs[i + 40] = 7'(8'h40 + i);
    end
    tbl[0]  = mk(1'b0, 8'h85, 1'b0, 1'b1, 1'b0, 7'h05, 1'b0, 1'b1);
    tbl[1]  = mk(1'b1, 8'h31, 1'b0, 1'b0, 1'b1, 7'h06, 1'b0, 1'b1);
    tbl[2]  = mk(1'b0, 8'hA7, 1'b0, 1'b1, 1'b0, 7'h27, 1'b0, 1'b1);
    tbl[3]  = mk(1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 7'h40, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 7'h40, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
    tbl[6]  = mk(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 7'h67, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 8'hA8, 1'b1, 1'b0, 1'b0, 7'h67, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 8'h0C, 1'b0, 1'b1, 1'b0, 7'h67, 1'b1, 1'b1);
    tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h67, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1);
    tbl[11] = mk(1'b0, 8'hE8, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);

    // Reset values while held in reset.
    #1;
    chk("reset.busy", busy, 1'b0);
    chk("reset.addr_cnt", addr_cnt, 7'h00);
    chk("reset.disp_on", disp_on, 1'b0);
    chk("reset.cmd_code", cmd_code, 8'h00);
    repeat (3) tick();
    rst = 1'b1;
    model_reset(cyc);
    busy_len("poweron");
    check_mem("poweron");
    chk("poweron.addr_cnt", addr_cnt, 7'h00);

    for (int i = 0; i < 12; i++) begin
      wait_until(m_busy_end);
      xfer(tbl[i].rs, 1'b0, tbl[i].db, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_err", i),  err,        tbl[i].x_err);
      chk($sformatf("vec%0d.tbl_cmd", i),  cmd_valid,  tbl[i].x_cmd);
      chk($sformatf("vec%0d.tbl_char", i), char_valid, tbl[i].x_char);
      chk($sformatf("vec%0d.tbl_addr", i), addr_cnt,   tbl[i].x_addr);
      chk($sformatf("vec%0d.tbl_disp", i), disp_on,    tbl[i].x_disp);
      chk($sformatf("vec%0d.tbl_busy", i), busy,       tbl[i].x_busy);
    end
    rd_addr = 7'h05; #1; chk("tbl.rd05", rd_data, 8'h31);
    rd_addr = 7'h27; #1; chk("tbl.rd27", rd_data, 8'h41);
    rd_addr = 7'h00; #1; chk("tbl.rd00", rd_data, 8'h42);

    // Data write while busy is dropped.
    wait_until(m_busy_end);
    xfer(1'b1, 1'b0, 8'h5A, "wr_ok");
    xfer(1'b1, 1'b0, 8'h7E, "wr_busy");
    chk("wr_busy.err", err, 1'b1);
    rd_addr = 7'h67; #1; chk("wr_busy.rd67", rd_data, 8'h20);
    rd_addr = 7'h00; #1; chk("wr_busy.rd00", rd_data, 8'h5A);
    tick();
    chk("wr_busy.err_one_cycle", err, 1'b0);

    // Busy boundary: last busy cycle rejects, first idle cycle accepts.
    wait_until(m_busy_end);
    xfer(1'b0, 1'b0, 8'h06, "bnd_entry");
    wait_until(m_busy_end - 1);
    xfer(1'b1, 1'b0, 8'h61, "bnd_last_busy");
    chk("bnd_last_busy.err", err, 1'b1);
    wait_until(m_busy_end);
    xfer(1'b1, 1'b0, 8'h62, "bnd_first_idle");
    chk("bnd_first_idle.char_valid", char_valid, 1'b1);
    tick();
    chk("bnd_first_idle.pulse_one_cycle", char_valid, 1'b0);

    // Read transactions are inert.
    wait_until(m_busy_end);
    xfer(1'b1, 1'b1, 8'h55, "read_txn");

    // Clear with display on.
    wait_until(m_busy_end);
    xfer(1'b0, 1'b0, 8'h0C, "disp_ctrl");
    chk("disp_ctrl.disp_on", disp_on, 1'b1);
    wait_until(m_busy_end);
    xfer(1'b0, 1'b0, 8'h01, "clear");
    busy_len("clear");
    check_mem("clear");
    chk("clear.disp_on", disp_on, 1'b1);
    chk("clear.addr_cnt", addr_cnt, 7'h00);

    // Reset in the middle of a clear fill.
    wait_until(m_busy_end);
    xfer(1'b1, 1'b0, 8'h33, "pre_clr");
    wait_until(m_busy_end);
    xfer(1'b0, 1'b0, 8'h01, "clr2");
    repeat (30) tick();
    rst = 1'b0;
    #1;
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.disp_on", disp_on, 1'b0);
    chk("midrst.cmd_code", cmd_code, 8'h00);
    chk("midrst.char_code", char_code, 8'h00);
    chk("midrst.char_addr", char_addr, 7'h00);
    chk("midrst.addr_cnt", addr_cnt, 7'h00);
    repeat (2) tick();
    rst = 1'b1;
    model_reset(cyc);
    busy_len("midrst");
    check_mem("midrst");

    // Random transactions against the model.
    for (int t = 0; t < 80; t++) begin
      logic       rs, rw;
      logic [7:0] db;
      int         k;
      rw = ($urandom_range(0, 9) == 0);
      rs = 1'($urandom_range(0, 1));
      db = 8'($urandom);
      if (!rs) begin
        k = $urandom_range(0, 9);
        case (k)
          0: db = ($urandom_range(0, 3) != 0) ? {1'b1, valid_addrs[$urandom_range(0, 79)]}
                                               : {1'b1, 7'($urandom)};
          1: db = 8'h40 | (db & 8'h3F);
          2: db = 8'h20 | (db & 8'h1F);
          3: db = 8'h10 | (db & 8'h0F);
          4: db = 8'h08 | (db & 8'h07);
          5: db = 8'h04 | (db & 8'h03);
          6: db = 8'h02 | (db & 8'h01);
          7: db = ($urandom_range(0, 3) == 0) ? 8'h01 : (8'h08 | (db & 8'h07));
          8: db = 8'h00;
          default: begin end
        endcase
      end
      if ($urandom_range(0, 3) != 0) wait_until(m_busy_end + $urandom_range(0, 2));
      xfer(rs, rw, db, $sformatf("rand%0d", t));
      if (e_char) begin
        rd_addr = m_char_addr;
        #1;
        chk($sformatf("rand%0d.rd", t), rd_data, m_mem[m_char_addr]);
      end
    end
    wait_until(m_busy_end);
    repeat (2) tick();
    check_mem("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
